blocking_relay_fifo: RTL and testbench
======================================

Name: blocking_relay_fifo

Overview:
- Parametrised successor to the single-register blocking in/out skeleton. Accepts words on a blocking input port, adds a running offset, and buffers results in a DEPTH-entry FIFO. Drains the FIFO on a blocking output port.
- Both ports use the sync/notify handshake:
  - the block drives notify to signal readiness;
  - the partner drives sync;
  - a transfer occurs in any cycle where both are high.
- Sits between two generated SCAM-model modules, decoupling producer and consumer by up to DEPTH words.

Parameters:
- DATA_W, 32, width of b_in, b_out, the offset register and the FIFO entries.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- OFFSET_INIT, 4, reset value of the running offset register.
- OFFSET_STEP, 1, amount added to the offset after each accepted input word.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high, sampled on rising clk.
- b_in  input  DATA_W  input data, sampled when an input transfer occurs.
- b_in_sync  input  1  producer offers a word.
- b_in_notify  output  1  block can accept a word.
- b_out  output  DATA_W  head-of-FIFO data; meaningful only while b_out_notify=1.
- b_out_sync  input  1  consumer takes a word.
- b_out_notify  output  1  block holds a word for the consumer.
- nb_result  output  1  one-cycle pulse: input offered but refused.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at a rising edge) sets the following, whatever transfer is in flight; that cycle's transfers are discarded:
  - b_in_notify=1, b_out_notify=0, nb_result=0, count=0;
  - read and write pointers=0;
  - offset register=OFFSET_INIT;
  - all FIFO entries=0, hence b_out=0.
- Transfer conditions:
  - push = b_in_sync & b_in_notify
  - pop = b_out_sync & b_out_notify
- Push: mem[wr_ptr] <= (b_in + offset) mod 2^DATA_W. Then wr_ptr advances and wraps modulo DEPTH. After the push, offset <= (offset + OFFSET_STEP) mod 2^DATA_W.
- Pop: rd_ptr advances and wraps modulo DEPTH.
- b_out = mem[rd_ptr], a combinational read of registered storage.
- Occupancy: count_next = count + push - pop. Simultaneous push and pop leaves count unchanged; both pointers advance.
- Notifies are registered from the next state:
  - b_in_notify <= (count_next != DEPTH)
  - b_out_notify <= (count_next != 0)
- Latency: a word pushed in cycle N is visible, with b_out_notify=1, from cycle N+1.
- Full (count=DEPTH): b_in_notify=0, so no push. A pop in that cycle raises b_in_notify in the next cycle; there is no same-cycle pass-through.
- Empty (count=0): b_out_notify=0, so no pop. A push into an empty FIFO raises b_out_notify in the next cycle; no bypass path.
- nb_result <= b_in_sync & ~b_in_notify. It is registered, so it pulses the cycle after each refused offer, and repeats every cycle the offer persists. It does not affect state.
- Outside transfer cycles the block ignores b_in and the sync inputs.
- No protocol error outputs.

Decomposition:
- Package relay_types holds:
  - localparams DEFAULT_DATA_W=32, DEFAULT_DEPTH=4, DEFAULT_OFFSET_INIT=4;
  - a typedef for the handshake pair, struct {logic sync; logic notify;};
  - an enum for the bench's status codes.
- One sub-module, relay_fifo_mem. It is parametrised by DATA_W and DEPTH, with a write port, a registered synchronous-reset array and a combinational read port.
- Pointer, count, offset and notify logic stay in the top.

Test Plan:
- Reset then idle: assert rst for 2 cycles, release → b_in_notify=1, b_out_notify=0, b_out=0, count=0, nb_result=0.
- Single word: b_in=10 with b_in_sync=1 for one cycle → next cycle b_out_notify=1 and b_out=14. Then b_out_sync=1 for one cycle → next cycle b_out_notify=0, count=0.
- Fill to full:
  - push 1,2,3,4 in consecutive cycles with the consumer idle;
  - → FIFO holds 5,7,9,11; count=4, b_in_notify=0;
  - hold b_in_sync=1 for 2 more cycles → nb_result pulses on 2 cycles, count stays 4.
  - Drain 4 words → outputs in order 5,7,9,11, then b_out_notify=0.
- Simultaneous push/pop at count=2 with b_in=100:
  - → count stays 2, both pointers advance;
  - stored value = 100 + current offset;
  - with DEPTH=4, repeat 6 times to check pointer wrap and ordering.
- Offset wrap: DATA_W=8, OFFSET_INIT=250, b_in=10 → b_out=4 (mod 256); the next offset is 251.
- Reset mid-operation: with count=3, assert rst on a cycle where push and pop are both high → next cycle count=0, b_out_notify=0, b_in_notify=1, offset=OFFSET_INIT; the pushed word is lost.

Source files
------------

// File: rtl/blocking_relay_fifo_pkg.sv
// Shared types and defaults for the blocking relay FIFO and its bench.
package relay_types;

    localparam int DEFAULT_DATA_W      = 32;
    localparam int DEFAULT_DEPTH       = 4;
    localparam int DEFAULT_OFFSET_INIT = 4;

    // One blocking port: the partner drives sync, this block drives notify.
    typedef struct packed {
        logic sync;
        logic notify;
    } hs_t;

    // Outcome codes used by the bench when summarising a run.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PASS    = 2'd1,
        ST_BAD     = 2'd2,
        ST_TIMEOUT = 2'd3
    } status_e;

endpackage

// File: rtl/relay_fifo_mem.sv
// FIFO storage: one write port, registered array cleared by reset,
// combinational read port.
module relay_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next array contents: only the addressed entry changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage register; reset clears every entry so the head reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/blocking_relay_fifo.sv
// Blocking relay: accepts words on a sync/notify input port, adds a running
// offset, buffers them in a DEPTH-entry FIFO and offers them on a sync/notify
// output port. Notifies are registered from the next occupancy, so there is
// no same-cycle bypass in either direction.
module blocking_relay_fifo
    import relay_types::*;
#(
    parameter int                DATA_W      = DEFAULT_DATA_W,
    parameter int                DEPTH       = DEFAULT_DEPTH,
    parameter logic [DATA_W-1:0] OFFSET_INIT = DATA_W'(DEFAULT_OFFSET_INIT),
    parameter logic [DATA_W-1:0] OFFSET_STEP = DATA_W'(1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          b_in,
    input  logic                       b_in_sync,
    output logic                       b_in_notify,
    output logic [DATA_W-1:0]          b_out,
    input  logic                       b_out_sync,
    output logic                       b_out_notify,
    output logic                       nb_result,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Modulo-2^DATA_W addition; the carry out is deliberately dropped.
    function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    hs_t in_hs;
    hs_t out_hs;

    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] offset_q, offset_d;
    logic             b_in_notify_q, b_in_notify_d;
    logic             b_out_notify_q, b_out_notify_d;
    logic             nb_result_q, nb_result_d;
    logic [DATA_W-1:0] push_data;

    assign in_hs  = '{sync: b_in_sync,  notify: b_in_notify_q};
    assign out_hs = '{sync: b_out_sync, notify: b_out_notify_q};

    // Transfer decisions and next state for pointers, occupancy, offset, flags.
    always_comb begin
        push           = in_hs.sync & in_hs.notify;
        pop            = out_hs.sync & out_hs.notify;
        push_data      = add_wrap(b_in, offset_q);
        wr_ptr_d       = wr_ptr_q + PTR_W'(push);
        rd_ptr_d       = rd_ptr_q + PTR_W'(pop);
        count_d        = count_q + CNT_W'(push) - CNT_W'(pop);
        offset_d       = push ? add_wrap(offset_q, OFFSET_STEP) : offset_q;
        b_in_notify_d  = (count_d != CNT_W'(DEPTH));
        b_out_notify_d = (count_d != '0);
        nb_result_d    = in_hs.sync & ~in_hs.notify;
    end

    // Control registers; reset discards any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            offset_q       <= OFFSET_INIT;
            b_in_notify_q  <= 1'b1;
            b_out_notify_q <= 1'b0;
            nb_result_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            offset_q       <= offset_d;
            b_in_notify_q  <= b_in_notify_d;
            b_out_notify_q <= b_out_notify_d;
            nb_result_q    <= nb_result_d;
        end
    end

    relay_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (push_data),
        .raddr (rd_ptr_q),
        .rdata (b_out)
    );

    assign b_in_notify  = b_in_notify_q;
    assign b_out_notify = b_out_notify_q;
    assign nb_result    = nb_result_q;
    assign count        = count_q;

endmodule

// File: tb/tb_blocking_relay_fifo.sv
// Bench for blocking_relay_fifo: directed scenarios plus a random run, all
// checked against a queue-based model of the relay.
module tb_blocking_relay_fifo;
    import relay_types::*;

    logic        clk;
    logic        rst;
    logic [31:0] b_in;
    logic        b_in_sync;
    logic        b_in_notify;
    logic [31:0] b_out;
    logic        b_out_sync;
    logic        b_out_notify;
    logic        nb_result;
    logic [2:0]  count;

    logic [7:0]  w_b_in;
    logic        w_in_sync;
    logic        w_in_notify;
    logic [7:0]  w_b_out;
    logic        w_out_sync;
    logic        w_out_notify;
    logic        w_nb_result;
    logic [2:0]  w_count;

    int total = 0;
    int bad   = 0;
    status_e st = ST_IDLE;

    // Reference model: queue of stored words, running offset, refusal flag.
    logic [31:0] mq[$];
    logic [31:0] m_off;
    bit          m_nb;

    blocking_relay_fifo dut (
        .clk          (clk),
        .rst          (rst),
        .b_in         (b_in),
        .b_in_sync    (b_in_sync),
        .b_in_notify  (b_in_notify),
        .b_out        (b_out),
        .b_out_sync   (b_out_sync),
        .b_out_notify (b_out_notify),
        .nb_result    (nb_result),
        .count        (count)
    );

    blocking_relay_fifo #(
        .DATA_W      (8),
        .DEPTH       (4),
        .OFFSET_INIT (8'd250),
        .OFFSET_STEP (8'd1)
    ) dut8 (
        .clk          (clk),
        .rst          (rst),
        .b_in         (w_b_in),
        .b_in_sync    (w_in_sync),
        .b_in_notify  (w_in_notify),
        .b_out        (w_b_out),
        .b_out_sync   (w_out_sync),
        .b_out_notify (w_out_notify),
        .nb_result    (w_nb_result),
        .count        (w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock on the main DUT: drive, clock, update model, settle at negedge.
    task automatic cycle(input bit isync, input logic [31:0] din, input bit osync);
        bit can_push;
        bit can_pop;
        b_in_sync  = isync;
        b_in       = din;
        b_out_sync = osync;
        can_push = isync && (mq.size() != 4);
        can_pop  = osync && (mq.size() != 0);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_off = 32'd4;
            m_nb  = 1'b0;
        end else begin
            m_nb = isync && (mq.size() == 4);
            if (can_pop) void'(mq.pop_front());
            if (can_push) begin
                mq.push_back(din + m_off);
                m_off = m_off + 32'd1;
            end
        end
        @(negedge clk);
        b_in_sync  = 1'b0;
        b_out_sync = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b0, 32'd0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b1, $urandom, 1'b1);
        cycle($urandom_range(0, 1) == 1, $urandom, 1'b1);
        rst = 1'b0;
        total++; if (b_in_notify !== 1'b1) begin bad++; $display("FAIL reset_in_notify: got %b want 1", b_in_notify); end
        total++; if (b_out_notify !== 1'b0) begin bad++; $display("FAIL reset_out_notify: got %b want 0", b_out_notify); end
        total++; if (b_out !== 32'd0) begin bad++; $display("FAIL reset_b_out: got %0d want 0", b_out); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (nb_result !== 1'b0) begin bad++; $display("FAIL reset_nb: got %b want 0", nb_result); end
        total++; if (w_b_out !== 8'd0 || w_in_notify !== 1'b1) begin bad++; $display("FAIL reset_w8: got out=%0d in_n=%b want 0/1", w_b_out, w_in_notify); end
    endtask

    task automatic test_single_word();
        cycle(1'b1, 32'd10, 1'b0);
        total++; if (b_out_notify !== 1'b1) begin bad++; $display("FAIL single_out_notify: got %b want 1", b_out_notify); end
        total++; if (b_out !== 32'd14) begin bad++; $display("FAIL single_b_out: got %0d want 14", b_out); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
        cycle(1'b0, 32'd0, 1'b1);
        total++; if (b_out_notify !== 1'b0) begin bad++; $display("FAIL single_drained_notify: got %b want 0", b_out_notify); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL single_drained_count: got %0d want 0", count); end
    endtask

    task automatic test_fill_full();
        logic [31:0] exp_words [4];
        exp_words = '{32'd5, 32'd7, 32'd9, 32'd11};
        do_reset();
        for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", count); end
        total++; if (b_in_notify !== 1'b0) begin bad++; $display("FAIL full_in_notify: got %b want 0", b_in_notify); end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, $urandom, 1'b0);
            total++; if (nb_result !== 1'b1) begin bad++; $display("FAIL full_nb_pulse%0d: got %b want 1", i, nb_result); end
            total++; if (count !== 3'd4) begin bad++; $display("FAIL full_hold_count%0d: got %0d want 4", i, count); end
        end
        cycle(1'b0, 32'd0, 1'b0);
        total++; if (nb_result !== 1'b0) begin bad++; $display("FAIL full_nb_clear: got %b want 0", nb_result); end
        for (int i = 0; i < 4; i++) begin
            total++; if (b_out !== exp_words[i] || b_out_notify !== 1'b1) begin bad++; $display("FAIL drain_word%0d: got %0d/%b want %0d/1", i, b_out, b_out_notify, exp_words[i]); end
            cycle(1'b0, 32'd0, 1'b1);
            if (i == 0) begin
                total++; if (b_in_notify !== 1'b1) begin bad++; $display("FAIL drain_in_notify: got %b want 1", b_in_notify); end
            end
        end
        total++; if (b_out_notify !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL drain_empty: got %b/%0d want 0/0", b_out_notify, count); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cycle(1'b1, $urandom, 1'b0);
        cycle(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 32'd100, 1'b1);
            total++; if (count !== 3'd2) begin bad++; $display("FAIL simul_count%0d: got %0d want 2", i, count); end
            total++; if (b_out !== mq[0]) begin bad++; $display("FAIL simul_head%0d: got %0d want %0d", i, b_out, mq[0]); end
        end
        // Last two stored words carry offsets 10 and 11.
        for (int i = 0; i < 2; i++) begin
            total++; if (b_out !== 32'(110 + i)) begin bad++; $display("FAIL simul_tail%0d: got %0d want %0d", i, b_out, 110 + i); end
            cycle(1'b0, 32'd0, 1'b1);
        end
    endtask

    task automatic test_offset_wrap();
        do_reset();
        w_b_in = 8'd10; w_in_sync = 1'b1;
        cycle(1'b0, 32'd0, 1'b0);
        w_in_sync = 1'b0;
        total++; if (w_b_out !== 8'd4 || w_out_notify !== 1'b1) begin bad++; $display("FAIL wrap_b_out: got %0d/%b want 4/1", w_b_out, w_out_notify); end
        w_b_in = 8'd0; w_in_sync = 1'b1; w_out_sync = 1'b1;
        cycle(1'b0, 32'd0, 1'b0);
        w_in_sync = 1'b0; w_out_sync = 1'b0;
        total++; if (w_b_out !== 8'd251 || w_count !== 3'd1) begin bad++; $display("FAIL wrap_next_offset: got %0d/%0d want 251/1", w_b_out, w_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0);
        total++; if (count !== 3'd3) begin bad++; $display("FAIL mid_pre_count: got %0d want 3", count); end
        rst = 1'b1;
        cycle(1'b1, 32'd55, 1'b1);
        rst = 1'b0;
        total++; if (count !== 3'd0 || b_out_notify !== 1'b0 || b_in_notify !== 1'b1) begin bad++; $display("FAIL mid_state: got cnt=%0d on=%b in=%b want 0/0/1", count, b_out_notify, b_in_notify); end
        total++; if (b_out !== 32'd0) begin bad++; $display("FAIL mid_b_out: got %0d want 0", b_out); end
        cycle(1'b1, 32'd0, 1'b0);
        total++; if (b_out !== 32'd4 || count !== 3'd1) begin bad++; $display("FAIL mid_offset: got %0d/%0d want 4/1", b_out, count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0 || i > 300);
            total++;
            if (count !== 3'(mq.size()) || b_in_notify !== (mq.size() != 4) ||
                b_out_notify !== (mq.size() != 0) || nb_result !== m_nb) begin
                bad++;
                $display("FAIL rand_ctrl%0d: got cnt=%0d in=%b on=%b nb=%b want cnt=%0d nb=%b",
                         i, count, b_in_notify, b_out_notify, nb_result, mq.size(), m_nb);
            end
            if (mq.size() != 0) begin
                total++;
                if (b_out !== mq[0]) begin bad++; $display("FAIL rand_data%0d: got %0h want %0h", i, b_out, mq[0]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; b_in = '0; b_in_sync = 1'b0; b_out_sync = 1'b0;
        w_b_in = '0; w_in_sync = 1'b0; w_out_sync = 1'b0;
        m_off = 32'd4; m_nb = 1'b0;
        test_reset();
        test_single_word();
        test_fill_full();
        test_simultaneous();
        test_offset_wrap();
        test_reset_mid();
        test_random();
        st = (bad == 0) ? ST_PASS : ST_BAD;
        if (st != ST_PASS && bad == 0) bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
